// File: rtl/mgr_cntl_arb.sv
// mgr_cntl_arb: buffers NoC dp channels, arbitrates whole packets round-robin onto MWC, decodes cp config writes
module mgr_cntl_arb #(
  parameter int NUM_DP_CH  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 64,
  parameter int TYPE_W     = 2,
  parameter int PTYPE_W    = 3,
  parameter int MGRID_W    = 6,
  parameter int ADDR_W     = 24,
  parameter bit ENABLE_RST = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_poweron,
  input  logic [MGRID_W-1:0]             sys__mgr__mgrId,
  input  logic                           noc__mcntl__cp_valid,
  input  logic [PTYPE_W-1:0]             noc__mcntl__cp_ptype,
  input  logic [DATA_W-1:0]              noc__mcntl__cp_data,
  input  logic [MGRID_W-1:0]             noc__mcntl__cp_mgrId,
  output logic                           mcntl__noc__cp_ready,
  input  logic [NUM_DP_CH-1:0]           noc__mcntl__dp_valid,
  input  logic [2*NUM_DP_CH-1:0]         noc__mcntl__dp_cntl,
  input  logic [TYPE_W*NUM_DP_CH-1:0]    noc__mcntl__dp_type,
  input  logic [PTYPE_W*NUM_DP_CH-1:0]   noc__mcntl__dp_ptype,
  input  logic [DATA_W*NUM_DP_CH-1:0]    noc__mcntl__dp_data,
  input  logic [MGRID_W*NUM_DP_CH-1:0]   noc__mcntl__dp_mgrId,
  output logic [NUM_DP_CH-1:0]           mcntl__noc__dp_ready,
  output logic                           mcntl__mwc__valid,
  output logic [1:0]                     mcntl__mwc__cntl,
  output logic [TYPE_W-1:0]              mcntl__mwc__type,
  output logic [PTYPE_W-1:0]             mcntl__mwc__ptype,
  output logic [DATA_W-1:0]              mcntl__mwc__data,
  output logic [MGRID_W-1:0]             mcntl__mwc__mgrId,
  input  logic                           mwc__mcntl__ready,
  output logic                           mcntl__mwc__flush,
  output logic [ADDR_W-1:0]              mcntl__wuf__start_addr,
  output logic                           mcntl__wuf__enable,
  output logic                           xxx__wuf__stall,
  output logic [7:0]                     mcntl__cp_drop_count
);
  localparam int W  = 2 + TYPE_W + PTYPE_W + DATA_W + MGRID_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = NUM_DP_CH > 1 ? $clog2(NUM_DP_CH) : 1;
  localparam logic [1:0] SOM = 2'b01, EOM = 2'b11;

  logic [W-1:0] head [NUM_DP_CH];
  logic [NUM_DP_CH-1:0] push, pop, empty, rdy;
  logic [CW-1:0] sel, sel_nxt, ptr, lock_ch;
  logic found, load, locked, out_valid, flush_pending, fire, cfg, match;
  logic [W-1:0] ob, hd;
  logic [1:0] hc;

  for (genvar i = 0; i < NUM_DP_CH; i++) begin : g_ch
    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0] cnt, cnt_n;
    assign push[i]  = noc__mcntl__dp_valid[i] & rdy[i];
    assign empty[i] = cnt == '0;
    assign head[i]  = mem[rp];
    assign cnt_n    = cnt + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    assign mcntl__noc__dp_ready[i] = rdy[i];
    always_ff @(posedge clk)
      if (push[i]) mem[wp] <= {noc__mcntl__dp_cntl[2*i +: 2], noc__mcntl__dp_type[TYPE_W*i +: TYPE_W],
                               noc__mcntl__dp_ptype[PTYPE_W*i +: PTYPE_W], noc__mcntl__dp_data[DATA_W*i +: DATA_W],
                               noc__mcntl__dp_mgrId[MGRID_W*i +: MGRID_W]};
    // ready comes from next-state occupancy so a full FIFO never sees a push
    always_ff @(posedge clk or posedge reset_poweron)
      if (reset_poweron) begin
        rp     <= '0;
        wp     <= '0;
        cnt    <= '0;
        rdy[i] <= 1'b1;
      end else begin
        rp     <= rp + AW'(pop[i]);
        wp     <= wp + AW'(push[i]);
        cnt    <= cnt_n;
        rdy[i] <= cnt_n != (AW+1)'(FIFO_DEPTH);
      end
  end

  // lowest offset from ptr wins; a held lock pins the grant to its channel
  always_comb begin
    sel   = lock_ch;
    found = locked & ~empty[lock_ch];
    if (!locked)
      for (int k = NUM_DP_CH - 1; k >= 0; k--)
        if (!empty[(int'(ptr) + k) % NUM_DP_CH]) begin
          found = 1'b1;
          sel   = CW'((int'(ptr) + k) % NUM_DP_CH);
        end
    hd      = head[sel];
    hc      = hd[W-1 -: 2];
    load    = found & (~out_valid | mwc__mcntl__ready);
    pop     = '0;
    pop[sel] = load;
    sel_nxt = int'(sel) == NUM_DP_CH - 1 ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or posedge reset_poweron)
    if (reset_poweron) begin
      out_valid <= 1'b0;
      ob        <= '0;
      locked    <= 1'b0;
      lock_ch   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      ob        <= hd;
      ptr       <= sel_nxt;
      if (!locked && hc == SOM) begin
        locked  <= 1'b1;
        lock_ch <= sel;
      end else if (locked && hc == EOM) locked <= 1'b0;
    end else if (mwc__mcntl__ready) out_valid <= 1'b0;

  always_ff @(posedge clk)
    if (!reset_poweron && load && !locked)
      assert (hc == 2'b00 || hc == SOM) else $error("mgr_cntl_arb: unlocked head beat on ch %0d is not a packet start", sel);

  assign mcntl__mwc__valid = out_valid;
  assign mcntl__mwc__cntl  = ob[W-1 -: 2];
  assign mcntl__mwc__type  = ob[MGRID_W+DATA_W+PTYPE_W +: TYPE_W];
  assign mcntl__mwc__ptype = ob[MGRID_W+DATA_W +: PTYPE_W];
  assign mcntl__mwc__data  = ob[MGRID_W +: DATA_W];
  assign mcntl__mwc__mgrId = ob[MGRID_W-1:0];

  assign match = noc__mcntl__cp_mgrId == sys__mgr__mgrId;
  assign cfg   = noc__mcntl__cp_valid & mcntl__noc__cp_ready & match;
  assign fire  = flush_pending & ~locked & ~out_valid & (&empty);

  always_ff @(posedge clk or posedge reset_poweron)
    if (reset_poweron) begin
      mcntl__noc__cp_ready   <= 1'b1;
      mcntl__wuf__start_addr <= '0;
      mcntl__wuf__enable     <= ENABLE_RST;
      xxx__wuf__stall        <= 1'b0;
      mcntl__cp_drop_count   <= '0;
      mcntl__mwc__flush      <= 1'b0;
      flush_pending          <= 1'b0;
    end else begin
      mcntl__noc__cp_ready <= 1'b1;
      if (cfg && noc__mcntl__cp_ptype == PTYPE_W'(0)) mcntl__wuf__start_addr <= noc__mcntl__cp_data[ADDR_W-1:0];
      if (cfg && noc__mcntl__cp_ptype == PTYPE_W'(1)) mcntl__wuf__enable <= noc__mcntl__cp_data[0];
      if (cfg && noc__mcntl__cp_ptype == PTYPE_W'(2)) xxx__wuf__stall <= noc__mcntl__cp_data[0];
      if (noc__mcntl__cp_valid && !match && mcntl__cp_drop_count != 8'hff)
        mcntl__cp_drop_count <= mcntl__cp_drop_count + 1'b1;
      mcntl__mwc__flush <= fire;
      flush_pending     <= ~fire & (flush_pending | (cfg && noc__mcntl__cp_ptype == PTYPE_W'(3)));
    end
endmodule
